// File: rtl/dist_search_if.sv
// Bus between dist_search, the candidate library, dist_calc and the search requester.
// DIST_SEARCH_EARLY_EXIT_EN adds the early_thresh input.
interface dist_search_if #(
  parameter int IDX_W = 8
);
  logic                              start;
  logic [IDX_W-1:0]                  num_cand;
  logic [IDX_W-1:0]                  lib_addr;
  logic signed [0:1][0:1][0:1][18:0] lib_data;
  logic signed [0:1][0:1][0:1][18:0] mtx_b;
  logic                              calc_ready;
  logic                              calc_finished;
  logic [37:0]                       calc_dist2;
  logic                              busy;
  logic                              done;
  logic [IDX_W-1:0]                  best_idx;
  logic [37:0]                       best_dist2;
  logic                              found;
  logic                              timeout_err;
`ifdef DIST_SEARCH_EARLY_EXIT_EN
  logic [37:0]                       early_thresh;

  modport slave (
    input  start, num_cand, lib_data, calc_finished, calc_dist2, early_thresh,
    output lib_addr, mtx_b, calc_ready, busy, done, best_idx, best_dist2, found, timeout_err
  );
  modport master (
    output start, num_cand, lib_data, calc_finished, calc_dist2, early_thresh,
    input  lib_addr, mtx_b, calc_ready, busy, done, best_idx, best_dist2, found, timeout_err
  );
`else
  modport slave (
    input  start, num_cand, lib_data, calc_finished, calc_dist2,
    output lib_addr, mtx_b, calc_ready, busy, done, best_idx, best_dist2, found, timeout_err
  );
  modport master (
    output start, num_cand, lib_data, calc_finished, calc_dist2,
    input  lib_addr, mtx_b, calc_ready, busy, done, best_idx, best_dist2, found, timeout_err
  );
`endif
endinterface

// File: rtl/dist_search.sv
// Sequencer for dist_calc: scans the candidate library and keeps the candidate with the largest dist2.
// Optional DIST_SEARCH_EARLY_EXIT_EN stops once the best dist2 reaches early_thresh.
module dist_search #(
  parameter int IDX_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  dist_search_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_CMP, S_DONE
  } state_t;

  state_t                            state, nxt;
  logic [IDX_W-1:0]                  idx, n_q, best_idx;
  logic [37:0]                       dist_q, best_dist2, best_nxt;
  logic signed [0:1][0:1][0:1][18:0] mtx_q;
  logic [CW-1:0]                     wcnt;
  logic                              found, tmo_err;
  logic                              better, last, early, tmo_hit;

  // First compared candidate always wins; afterwards only a strictly larger dist2.
  assign better   = !found || (dist_q > best_dist2);
  assign best_nxt = better ? dist_q : best_dist2;
  assign last     = (idx == n_q - IDX_W'(1));
  assign tmo_hit  = !bus.calc_finished && (wcnt == CW'(TIMEOUT - 1));

`ifdef DIST_SEARCH_EARLY_EXIT_EN
  assign early = (best_nxt >= bus.early_thresh);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.start) nxt = (bus.num_cand == '0) ? S_DONE : S_FETCH;
      S_FETCH: nxt = S_LOAD;
      S_LOAD:  nxt = S_ISSUE;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT: begin
        if (bus.calc_finished) nxt = S_CMP;
        else if (tmo_hit)      nxt = S_DONE;
      end
      S_CMP:   nxt = (last || early) ? S_DONE : S_FETCH;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      n_q        <= '0;
      mtx_q      <= '0;
      dist_q     <= '0;
      wcnt       <= '0;
      best_idx   <= '0;
      best_dist2 <= '0;
      found      <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          n_q        <= bus.num_cand;
          idx        <= '0;
          best_idx   <= '0;
          best_dist2 <= '0;
          found      <= 1'b0;
          tmo_err    <= 1'b0;
        end
        S_LOAD:  mtx_q <= bus.lib_data;
        S_ISSUE: wcnt  <= '0;
        S_WAIT: begin
          if (bus.calc_finished) dist_q <= bus.calc_dist2;
          else                   wcnt   <= wcnt + 1'b1;
          if (tmo_hit) tmo_err <= 1'b1;
        end
        S_CMP: begin
          if (better) begin
            best_idx   <= idx;
            best_dist2 <= best_nxt;
          end
          found <= 1'b1;
          if (nxt == S_FETCH) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // idx is a register, so the library address is stable from FETCH through LOAD.
  assign bus.lib_addr    = idx;
  assign bus.mtx_b       = mtx_q;
  assign bus.calc_ready  = (state == S_ISSUE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.best_idx    = best_idx;
  assign bus.best_dist2  = best_dist2;
  assign bus.found       = found;
  assign bus.timeout_err = tmo_err;
endmodule
